// File: rtl/serial_operand_adder_frontend_if.sv
// Bundle of the serial operand link, the adder operand/sum link and the
// downstream result handshake. The slave side is the frontend block; the
// master side is whatever drives the serial bits, provides the adder and
// consumes the result.
interface serial_operand_adder_frontend_if #(
    parameter int unsigned WIDTH = 4
);
    // Serial operand link
    logic             ser_valid;
    logic             ser_first;
    logic             ser_a;
    logic             ser_b;
    logic             ser_ready;

    // Adder link
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH:0]   add_s;

    // Result link
    logic             sum_valid;
    logic [WIDTH:0]   sum;
    logic             sum_ready;

    modport slave (
        input  ser_valid,
        input  ser_first,
        input  ser_a,
        input  ser_b,
        output ser_ready,
        output add_a,
        output add_b,
        input  add_s,
        output sum_valid,
        output sum,
        input  sum_ready
    );

    modport master (
        output ser_valid,
        output ser_first,
        output ser_a,
        output ser_b,
        input  ser_ready,
        input  add_a,
        input  add_b,
        output add_s,
        input  sum_valid,
        input  sum,
        output sum_ready
    );
endinterface

// File: rtl/serial_operand_adder_frontend.sv
// Serial-to-parallel operand stage in front of a combinational adder.
// Collects two WIDTH-bit operands LSB-first, presents them to the adder,
// registers the (WIDTH+1)-bit sum and offers it on a valid/ready output.
module serial_operand_adder_frontend #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    serial_operand_adder_frontend_if.slave        bus
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        CAPTURE = 2'd1,
        OUT     = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sh_a_q, sh_a_d;
    logic [WIDTH-1:0]  sh_b_q, sh_b_d;
    logic [WIDTH:0]    sum_q, sum_d;
    logic              sum_valid_q, sum_valid_d;

    logic              xfer;
    logic              frame_open;
    logic [CW-1:0]     cnt_next;

    // Ready is gated by rst_n so it drops together with the async reset.
    assign bus.ser_ready = (state_q == LOAD) && rst_n;
    assign xfer          = bus.ser_valid && bus.ser_ready;

    // A bit is kept if it opens a frame or extends an already open one;
    // a first-marked bit always restarts the count at one.
    assign frame_open    = bus.ser_first || (cnt_q != '0);
    assign cnt_next      = bus.ser_first ? CW'(1) : (cnt_q + CW'(1));

    assign bus.add_a     = sh_a_q;
    assign bus.add_b     = sh_b_q;
    assign bus.sum       = sum_q;
    assign bus.sum_valid = sum_valid_q;

    // Next-state logic for the framing FSM, shift registers and result.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        sum_d       = sum_q;
        sum_valid_d = sum_valid_q;

        unique case (state_q)
            LOAD: begin
                if (xfer && frame_open) begin
                    sh_a_d = {bus.ser_a, sh_a_q[WIDTH-1:1]};
                    sh_b_d = {bus.ser_b, sh_b_q[WIDTH-1:1]};
                    if (cnt_next == CW'(WIDTH)) begin
                        cnt_d   = '0;
                        state_d = CAPTURE;
                    end else begin
                        cnt_d   = cnt_next;
                    end
                end
            end

            CAPTURE: begin
                sum_d       = bus.add_s;
                sum_valid_d = 1'b1;
                state_d     = OUT;
            end

            OUT: begin
                if (bus.sum_ready) begin
                    sum_valid_d = 1'b0;
                    state_d     = LOAD;
                end
            end

            default: begin
                state_d     = LOAD;
                cnt_d       = '0;
                sum_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
        end
    end

endmodule

// File: tb/tb_serial_operand_adder_frontend.sv
// Bench for serial_operand_adder_frontend: acts as serial source, adder
// and result sink; results are checked through a scoreboard queue.
module tb_serial_operand_adder_frontend;

    logic clk;
    logic rst_n;

    serial_operand_adder_frontend_if #(.WIDTH(4)) bus ();

    serial_operand_adder_frontend #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Combinational adder standing in for the carry-look-ahead block.
    assign bus.add_s = {1'b0, bus.add_a} + {1'b0, bus.add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] s;
    } vec_t;

    vec_t sb[$];
    vec_t mon_e;
    vec_t tbl[8];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout at %0t", name, $time);
    endtask

    // Drive one bit pair; it transfers on the next rising edge.
    task automatic send_bit(input logic first, input logic a, input logic b);
        int unsigned k;
        k = 0;
        @(negedge clk);
        while (!bus.ser_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus.ser_ready) bound_fail("ser_ready_wait");
        bus.ser_valid = 1'b1;
        bus.ser_first = first;
        bus.ser_a     = a;
        bus.ser_b     = b;
        @(posedge clk);
        #1;
        bus.ser_valid = 1'b0;
        bus.ser_first = 1'b0;
    endtask

    task automatic send_frame(input vec_t v);
        sb.push_back(v);
        for (int i = 0; i < 4; i++)
            send_bit(i == 0, v.a[i], v.b[i]);
    endtask

    task automatic wait_valid();
        int unsigned k;
        k = 0;
        @(negedge clk);
        while (!bus.sum_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus.sum_valid) bound_fail("sum_valid_wait");
    endtask

    // Scoreboard consumer: compare at each accepted result.
    always @(negedge clk) begin
        if (rst_n && bus.sum_valid && bus.sum_ready) begin
            if (sb.size() == 0) begin
                bound_fail("unexpected_result");
            end else begin
                mon_e = sb.pop_front();
                check("sum",   32'(bus.sum),   32'(mon_e.s));
                check("add_a", 32'(bus.add_a), 32'(mon_e.a));
                check("add_b", 32'(bus.add_b), 32'(mon_e.b));
            end
        end
    end

    initial begin
        tbl[0] = '{a: 4'hF, b: 4'hF, s: 5'h1E};
        tbl[1] = '{a: 4'h0, b: 4'h0, s: 5'h00};
        tbl[2] = '{a: 4'h8, b: 4'h8, s: 5'h10};
        tbl[3] = '{a: 4'hA, b: 4'h5, s: 5'h0F};
        tbl[4] = '{a: 4'h9, b: 4'h7, s: 5'h10};
        tbl[5] = '{a: 4'hC, b: 4'h3, s: 5'h0F};
        tbl[6] = '{a: 4'hF, b: 4'h1, s: 5'h10};
        tbl[7] = '{a: 4'h2, b: 4'h4, s: 5'h06};

        rst_n         = 1'b0;
        bus.ser_valid = 1'b0;
        bus.ser_first = 1'b0;
        bus.ser_a     = 1'b0;
        bus.ser_b     = 1'b0;
        bus.sum_ready = 1'b1;

        // Reset state
        #12;
        check("rst_ser_ready", 32'(bus.ser_ready), 0);
        check("rst_sum_valid", 32'(bus.sum_valid), 0);
        check("rst_sum",       32'(bus.sum),       0);
        check("rst_add_a",     32'(bus.add_a),     0);
        check("rst_add_b",     32'(bus.add_b),     0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(bus.ser_ready), 1);

        // Basic add with latency check
        send_frame('{a: 4'hB, b: 4'h6, s: 5'h11});
        @(negedge clk);
        check("capture_valid", 32'(bus.sum_valid), 0);
        check("capture_ready", 32'(bus.ser_ready), 0);
        @(negedge clk);
        check("out_valid", 32'(bus.sum_valid), 1);
        check("out_sum",   32'(bus.sum),       32'h11);
        @(negedge clk);
        check("valid_one_cycle", 32'(bus.sum_valid), 0);

        // Table of frames, back to back
        for (int i = 0; i < 8; i++)
            send_frame(tbl[i]);
        wait_valid();
        @(negedge clk);

        // Backpressure hold with ignored serial pulses
        bus.sum_ready = 1'b0;
        send_frame('{a: 4'hB, b: 4'h6, s: 5'h11});
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            bus.ser_valid = 1'b1;
            bus.ser_first = 1'b1;
            bus.ser_a     = 1'b0;
            bus.ser_b     = 1'b1;
            @(posedge clk);
            #1;
            bus.ser_valid = 1'b0;
            bus.ser_first = 1'b0;
            @(negedge clk);
            check("hold_valid", 32'(bus.sum_valid), 1);
            check("hold_sum",   32'(bus.sum),       32'h11);
            check("hold_ready", 32'(bus.ser_ready), 0);
            check("hold_add_a", 32'(bus.add_a),     32'hB);
        end
        @(posedge clk);
        #1;
        bus.sum_ready = 1'b1;
        send_frame('{a: 4'h1, b: 4'h2, s: 5'h03});
        wait_valid();
        @(negedge clk);

        // Stray bit without a frame open is dropped
        send_bit(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("stray_add_a", 32'(bus.add_a), 32'h1);
        check("stray_add_b", 32'(bus.add_b), 32'h2);

        // Resync: partial frame then restarted frame
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b0, 1'b1, 1'b1);
        send_frame('{a: 4'h3, b: 4'h1, s: 5'h04});
        wait_valid();
        @(negedge clk);

        // Gapped input with latency check
        sb.push_back('{a: 4'h5, b: 4'h5, s: 5'h0A});
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        send_bit(1'b0, 1'b1, 1'b1);
        send_bit(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("gap_capture_valid", 32'(bus.sum_valid), 0);
        @(negedge clk);
        check("gap_out_valid", 32'(bus.sum_valid), 1);
        check("gap_out_sum",   32'(bus.sum),       32'h0A);
        @(negedge clk);

        // Async reset mid-LOAD
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_load_ready", 32'(bus.ser_ready), 0);
        check("arst_load_add_a", 32'(bus.add_a),     0);
        check("arst_load_add_b", 32'(bus.add_b),     0);
        check("arst_load_sum",   32'(bus.sum),       0);
        #3;
        rst_n = 1'b1;
        send_frame('{a: 4'h6, b: 4'h7, s: 5'h0D});
        wait_valid();
        @(negedge clk);

        // Async reset while holding a result in OUT
        bus.sum_ready = 1'b0;
        send_frame('{a: 4'h9, b: 4'h7, s: 5'h10});
        wait_valid();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.sum_valid), 0);
        check("arst_out_sum",   32'(bus.sum),       0);
        check("arst_out_add_a", 32'(bus.add_a),     0);
        check("arst_out_ready", 32'(bus.ser_ready), 0);
        sb.delete();
        #1;
        rst_n = 1'b1;
        bus.sum_ready = 1'b1;
        send_frame('{a: 4'hE, b: 4'h3, s: 5'h11});
        wait_valid();
        repeat (3) @(negedge clk);

        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
